// File: rtl/adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_capture
// Purpose  : Triggered ADC capture into a 2^DEPTH_LOG2 buffer, streamed out.
//            Optional macro ADC_CAPTURE_OTR_EN adds out-of-range handling.
// Revision : 1.0 - initial release
// ============================================================================
module adc_capture #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [13:0] adc_data,
    input  logic        adc_otr,
    input  logic        arm,
    input  logic        force_trig,
    input  logic [13:0] trig_level,
    output logic        busy,
    output logic        done,
    output logic [13:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic        rd_last,
    output logic        rd_otr,
    output logic [15:0] ovr_count
);

    localparam int                    c_DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] c_LAST_ADDR = '1;

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_ARMED   = 2'd1;
    localparam logic [1:0] c_CAPTURE = 2'd2;
    localparam logic [1:0] c_DONE    = 2'd3;

    logic [1:0]              r_state;
    logic [13:0]             r_pin_data;
    logic signed [13:0]      r_samp;
    logic signed [13:0]      r_prev;
    logic                    r_prev_valid;
    logic [DEPTH_LOG2-1:0]   r_waddr;
    logic [DEPTH_LOG2-1:0]   r_raddr;
    logic                    r_rd_end;
    logic [13:0]             r_ram_q;
    logic                    r_ram_v;
    logic                    r_ram_last;
    logic [13:0]             r_rd_data;
    logic                    r_rd_valid;
    logic                    r_rd_last;
    logic [13:0]             r_mem [c_DEPTH];

    logic                    w_cross;
    logic                    w_trig;
    logic                    w_we;
    logic                    w_move;
    logic                    w_issue;
    logic                    w_last_xfer;
    logic [13:0]             w_store;

    assign w_cross     = r_prev_valid && (r_prev < $signed(trig_level)) &&
                         (r_samp >= $signed(trig_level));
    assign w_trig      = (r_state == c_ARMED) && (force_trig || w_cross);
    assign w_we        = w_trig || (r_state == c_CAPTURE);
    // Two-stage read pipeline: RAM output register feeds the presented word,
    // so the next read is only issued when the RAM stage will be vacated.
    assign w_move      = r_ram_v && (!r_rd_valid || rd_ready);
    assign w_issue     = (r_state == c_DONE) && !r_rd_end && (!r_ram_v || w_move);
    assign w_last_xfer = (r_state == c_DONE) && r_rd_valid && rd_ready && r_rd_last;

    assign busy     = (r_state == c_ARMED) || (r_state == c_CAPTURE);
    assign done     = (r_state == c_DONE);
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_last  = r_rd_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= c_IDLE;
            r_pin_data   <= '0;
            r_samp       <= '0;
            r_prev       <= '0;
            r_prev_valid <= 1'b0;
            r_waddr      <= '0;
            r_raddr      <= '0;
            r_rd_end     <= 1'b0;
            r_ram_v      <= 1'b0;
            r_ram_last   <= 1'b0;
            r_rd_data    <= '0;
            r_rd_valid   <= 1'b0;
            r_rd_last    <= 1'b0;
        end else begin
            r_pin_data <= adc_data;
            r_samp     <= {~r_pin_data[13], r_pin_data[12:0]};
            case (r_state)
                c_IDLE: begin
                    if (arm) begin
                        r_state      <= c_ARMED;
                        r_prev_valid <= 1'b0;
                        r_waddr      <= '0;
                    end
                end
                c_ARMED: begin
                    r_prev       <= r_samp;
                    r_prev_valid <= 1'b1;
                    if (w_trig) begin
                        r_state <= c_CAPTURE;
                        r_waddr <= DEPTH_LOG2'(1);
                    end
                end
                c_CAPTURE: begin
                    r_waddr <= r_waddr + 1'b1;
                    if (r_waddr == c_LAST_ADDR) begin
                        r_state <= c_DONE;
                    end
                end
                c_DONE: begin
                    if (w_issue) begin
                        r_raddr    <= r_raddr + 1'b1;
                        r_rd_end   <= (r_raddr == c_LAST_ADDR);
                        r_ram_last <= (r_raddr == c_LAST_ADDR);
                        r_ram_v    <= 1'b1;
                    end else if (w_move) begin
                        r_ram_v <= 1'b0;
                    end
                    if (w_move) begin
                        r_rd_data  <= r_ram_q;
                        r_rd_last  <= r_ram_last;
                        r_rd_valid <= 1'b1;
                    end else if (r_rd_valid && rd_ready) begin
                        r_rd_valid <= 1'b0;
                    end
                    if (w_last_xfer) begin
                        r_state    <= c_IDLE;
                        r_raddr    <= '0;
                        r_rd_end   <= 1'b0;
                        r_ram_v    <= 1'b0;
                        r_rd_valid <= 1'b0;
                        r_rd_last  <= 1'b0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_waddr] <= w_store;
        end
        if (w_issue) begin
            r_ram_q <= r_mem[r_raddr];
        end
    end

`ifdef ADC_CAPTURE_OTR_EN
    logic        r_pin_otr;
    logic        r_samp_otr;
    logic        r_ram_otr;
    logic        r_rd_otr;
    logic [15:0] r_ovr_count;
    logic        r_mem_otr [c_DEPTH];

    // Clamp to the rail the converter overflowed toward (raw MSB set = positive).
    assign w_store   = r_samp_otr ? (r_samp[13] ? 14'h2000 : 14'h1FFF) : r_samp;
    assign rd_otr    = r_rd_otr;
    assign ovr_count = r_ovr_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pin_otr   <= 1'b0;
            r_samp_otr  <= 1'b0;
            r_rd_otr    <= 1'b0;
            r_ovr_count <= '0;
        end else begin
            r_pin_otr  <= adc_otr;
            r_samp_otr <= r_pin_otr;
            if (w_move) begin
                r_rd_otr <= r_ram_otr;
            end
            if ((r_state == c_IDLE) && arm) begin
                r_ovr_count <= '0;
            end else if (w_we && r_samp_otr && (r_ovr_count != 16'hFFFF)) begin
                r_ovr_count <= r_ovr_count + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem_otr[r_waddr] <= r_samp_otr;
        end
        if (w_issue) begin
            r_ram_otr <= r_mem_otr[r_raddr];
        end
    end
`else
    logic w_unused_otr;

    assign w_unused_otr = adc_otr;
    assign w_store      = r_samp;
    assign rd_otr       = 1'b0;
    assign ovr_count    = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_capture
// Purpose  : Randomised scoreboard bench for adc_capture (honours ADC_CAPTURE_OTR_EN).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_capture;

`ifdef ADC_CAPTURE_OTR_EN
    localparam bit c_OTR_EN = 1'b1;
`else
    localparam bit c_OTR_EN = 1'b0;
`endif
    localparam int c_WORDS = 1024;

    logic        clk;
    logic        reset;
    logic [13:0] adc_data;
    logic        adc_otr;
    logic        arm;
    logic        force_trig;
    logic [13:0] trig_level;
    logic        busy;
    logic        done;
    logic [13:0] rd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic        rd_last;
    logic        rd_otr;
    logic [15:0] ovr_count;

    adc_capture #(.DEPTH_LOG2(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .adc_data   (adc_data),
        .adc_otr    (adc_otr),
        .arm        (arm),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .busy       (busy),
        .done       (done),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .rd_otr     (rd_otr),
        .ovr_count  (ovr_count)
    );

    typedef struct packed {
        logic [13:0] d;
        logic        o;
        logic        l;
    } exp_t;

    exp_t        exp_q[$];
    logic [13:0] q_d[$];
    logic        q_o[$];
    int          total = 0;
    int          bad = 0;
    int          exp_ovr = 0;
    int          rd_mode = 0;
    bit          saw_done = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h required=%0h", name, got, want);
        end
    endtask

    // Offset-binary code to signed sample value.
    function automatic int sval(input logic [13:0] raw);
        return int'(raw) - 8192;
    endfunction

    function automatic logic [13:0] stored(input logic [13:0] raw, input logic o);
        int v;
        v = sval(raw);
        if (o && c_OTR_EN) v = raw[13] ? 8191 : -8192;
        return v[13:0];
    endfunction

    function automatic int find_trig(input logic [13:0] lvl);
        int l;
        l = int'($signed(lvl));
        for (int i = 1; i < q_d.size(); i++)
            if (sval(q_d[i-1]) < l && sval(q_d[i]) >= l) return i;
        return -1;
    endfunction

    task automatic push_expected(input int t);
        exp_t e;
        exp_ovr = 0;
        for (int k = 0; k < c_WORDS; k++) begin
            e.d = stored(q_d[t+k], q_o[t+k]);
            e.o = q_o[t+k] && c_OTR_EN;
            e.l = (k == c_WORDS - 1);
            if (e.o) exp_ovr++;
            exp_q.push_back(e);
        end
    endtask

    task automatic drive(input logic [13:0] d, input logic o, input logic a, input logic f);
        adc_data   = d;
        adc_otr    = o;
        arm        = a;
        force_trig = f;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        arm = 1'b0;
        force_trig = 1'b0;
        while ((busy || done) && n < 6000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_back_idle"}, {30'd0, busy, done}, 32'd0);
        check({tag, "_saw_done"}, {31'd0, saw_done}, 32'd1);
        check({tag, "_words_left"}, exp_q.size(), 32'd0);
        check({tag, "_ovr_count"}, {16'd0, ovr_count}, exp_ovr);
        check({tag, "_rd_valid_idle"}, {31'd0, rd_valid}, 32'd0);
        exp_q.delete();
    endtask

    task automatic level_capture(input string tag, input logic [13:0] lvl);
        int t;
        t = find_trig(lvl);
        if (t < 0 || t + c_WORDS > q_d.size()) begin
            $display("FAIL %s_stimulus got=%0d required=valid_trigger", tag, t);
            $fatal(1, "bad stimulus");
        end
        saw_done   = 1'b0;
        trig_level = lvl;
        push_expected(t);
        repeat (4) drive(q_d[0], 1'b0, 1'b0, 1'b0);
        drive(q_d[0], 1'b0, 1'b1, 1'b0);
        foreach (q_d[i]) drive(q_d[i], q_o[i], 1'b0, 1'b0);
        wait_idle(tag);
    endtask

    task automatic gen_ramp();
        q_d.delete();
        q_o.delete();
        repeat (12) begin q_d.push_back(14'h1F00); q_o.push_back(1'b0); end
        for (int k = 0; k < 1536; k++) begin
            q_d.push_back(14'(14'h1F00 + k));
            q_o.push_back(1'b0);
        end
    endtask

    task automatic gen_random(output logic [13:0] lvl);
        int l;
        int t;
        do begin
            l = int'($urandom_range(0, 8000)) - 4000;
            lvl = 14'(l);
            q_d.delete();
            q_o.delete();
            repeat (12) begin q_d.push_back(14'(l - 100 + 8192)); q_o.push_back(1'b0); end
            for (int i = 0; i < 1400; i++) begin
                if ($urandom_range(0, 15) == 0) begin
                    q_d.push_back(($urandom_range(0, 1) == 1) ? 14'h3FFF : 14'h0000);
                    q_o.push_back(1'b1);
                end else begin
                    q_d.push_back(14'($urandom_range(0, 16383)));
                    q_o.push_back(1'b0);
                end
            end
            t = find_trig(lvl);
        end while (t < 0 || t > 300);
    endtask

    initial begin
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rd_mode)
                0:       rd_ready = 1'b1;
                1:       rd_ready = ~rd_ready;
                default: rd_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    logic        hold_p = 1'b0;
    logic [15:0] held;

    always @(negedge clk) begin
        exp_t e;
        if (done) saw_done = 1'b1;
        if (reset || !rd_valid) begin
            hold_p = 1'b0;
        end else begin
            if (hold_p) check("stall_hold", {16'd0, rd_data, rd_otr, rd_last}, {16'd0, held});
            if (rd_ready) begin
                hold_p = 1'b0;
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL extra_word got=%0d required=none", $signed(rd_data));
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", {18'd0, rd_data}, {18'd0, e.d});
                    check("word_otr_last", {30'd0, rd_otr, rd_last}, {30'd0, e.o, e.l});
                end
            end else begin
                hold_p = 1'b1;
                held   = {rd_data, rd_otr, rd_last};
            end
        end
    end

    initial begin
        logic [13:0] lvl;
        reset = 1'b1; adc_data = '0; adc_otr = 1'b0; arm = 1'b0;
        force_trig = 1'b0; trig_level = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy_done", {30'd0, busy, done}, 32'd0);
        check("reset_rd_flags", {29'd0, rd_valid, rd_last, rd_otr}, 32'd0);
        check("reset_rd_data", {18'd0, rd_data}, 32'd0);
        check("reset_ovr", {16'd0, ovr_count}, 32'd0);
        reset = 1'b0;

        // Ramp through zero with a zero threshold.
        rd_mode = 0;
        gen_ramp();
        level_capture("ramp", 14'h0000);

        // Constant input never crosses; long armed wait, then forced trigger
        // with arm held high through capture and readout.
        saw_done = 1'b0;
        trig_level = 14'h1FFF;
        repeat (4) drive(14'h3000, 1'b0, 1'b0, 1'b0);
        drive(14'h3000, 1'b0, 1'b1, 1'b0);
        repeat (5000) drive(14'h3000, 1'b0, 1'b0, 1'b0);
        check("armed_busy", {31'd0, busy}, 32'd1);
        check("armed_done", {31'd0, done}, 32'd0);
        q_d.delete(); q_o.delete();
        repeat (c_WORDS) begin q_d.push_back(14'h3000); q_o.push_back(1'b0); end
        push_expected(0);
        drive(14'h3000, 1'b0, 1'b0, 1'b1);
        repeat (1100) drive(14'h3000, 1'b0, 1'b1, 1'b0);
        wait_idle("force");

        // Toggling ready during readout.
        rd_mode = 1;
        gen_random(lvl);
        level_capture("toggle", lvl);

        // Reset roughly 500 words into a capture, then a clean capture.
        rd_mode = 2;
        trig_level = 14'h0000;
        repeat (4) drive(14'h3000, 1'b0, 1'b0, 1'b0);
        drive(14'h3000, 1'b0, 1'b1, 1'b0);
        repeat (3) drive(14'h3000, 1'b0, 1'b0, 1'b0);
        drive(14'h3000, 1'b0, 1'b0, 1'b1);
        repeat (498) drive(14'h3000, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        drive(14'h3000, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check("midreset_busy_done", {30'd0, busy, done}, 32'd0);
        check("midreset_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midreset_ovr", {16'd0, ovr_count}, 32'd0);
        gen_random(lvl);
        level_capture("after_reset", lvl);

        // Ten out-of-range full-scale samples inside the captured window.
        rd_mode = 0;
        gen_ramp();
        for (int j = 0; j < 10; j++) begin
            q_d[300 + j] = 14'h3FFF;
            q_o[300 + j] = 1'b1;
        end
        level_capture("otr", 14'h0000);

        rd_mode = 2;
        for (int r = 0; r < 2; r++) begin
            gen_random(lvl);
            level_capture("random", lvl);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
